// File: rtl/cond_unit.sv
// Condition unit: holds the NZCV flag register, evaluates ARM condition codes and gates write strobes.
// Optional execute/skip performance counters are built when COND_PERF_CNT_EN is defined.
module cond_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Valid,
    input  logic             Stall,
    input  logic             Flush,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             Carry,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    logic [3:0] flags_q, flags_d;
    logic       condpass;
    logic       upd_en;

    // Decode uses only the registered flags; no bypass of the ALU's same-cycle flags.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = cy;
            4'b0011: cond_pass = ~cy;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = cy & ~z;
            4'b1001: cond_pass = ~cy | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

    always_comb begin
        condpass = cond_pass(Cond, flags_q);
        CondEx   = Valid & ~Flush & condpass;
        PCSrc    = PCS & CondEx;
        RegWrite = RegW & CondEx & ~NoWrite;
        MemWrite = MemW & CondEx;
        upd_en   = CondEx & ~Stall;
    end

    always_comb begin
        flags_d = flags_q;
        if (upd_en) begin
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) flags_q <= 4'b0000;
        else         flags_q <= flags_d;
    end

    assign Flags = flags_q;
    assign Carry = flags_q[1];

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic             cnt_en;

    // Stalled cycles are not counted so a held instruction is counted exactly once.
    always_comb begin
        cnt_en = Valid & ~Flush & ~Stall;
        exec_d = exec_q;
        skip_d = skip_q;
        if (cnt_en) begin
            if (condpass) exec_d = exec_q + 1'b1;
            else          skip_d = skip_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            exec_q <= '0;
            skip_q <= '0;
        end else begin
            exec_q <= exec_d;
            skip_q <= skip_d;
        end
    end

    assign ExecCount = exec_q;
    assign SkipCount = skip_q;
`else
    assign ExecCount = '0;
    assign SkipCount = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed testbench for cond_unit: flag register, condition decode, strobe gating, stall/flush/reset
// and the optional performance counters (CNT_W=4).
module tb_cond_unit;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RESETn;
    logic             Valid, Stall, Flush;
    logic [3:0]       Cond, ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW, NoWrite;
    logic             CondEx, PCSrc, RegWrite, MemWrite;
    logic [3:0]       Flags;
    logic             Carry;
    logic [CNT_W-1:0] ExecCount, SkipCount;

    int errors = 0;
    int checks = 0;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESETn(RESETn), .Valid(Valid), .Stall(Stall), .Flush(Flush),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .CondEx(CondEx), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags), .Carry(Carry),
        .ExecCount(ExecCount), .SkipCount(SkipCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESETn = 1'b0; Valid = 0; Stall = 0; Flush = 0; Cond = 4'h0; ALUFlags = 4'h0;
        FlagW = 2'b00; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
        #12;
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_carry", Carry, 1'b0);
        chk("rst_condex_novalid", CondEx, 1'b0);
        chk("rst_exec", ExecCount, 0);
        chk("rst_skip", SkipCount, 0);
        RESETn = 1'b1;

        // 1: EQ fails on zero flags, NE passes
        Valid = 1; Cond = 4'b0000; RegW = 1;
        #1;
        chk("eq_fail_condex", CondEx, 1'b0);
        chk("eq_fail_regwrite", RegWrite, 1'b0);
        Cond = 4'b0001;
        #1;
        chk("ne_pass_condex", CondEx, 1'b1);
        chk("ne_pass_regwrite", RegWrite, 1'b1);

        // 2: CMP then BEQ / BNE
        tick();
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1; NoWrite = 1;
        #1;
        chk("cmp_regwrite", RegWrite, 1'b0);
        chk("cmp_condex", CondEx, 1'b1);
        tick();
        chk("cmp_flags", Flags, 4'b0100);
        FlagW = 2'b00; RegW = 0; NoWrite = 0; PCS = 1; Cond = 4'b0000; ALUFlags = 4'b0000;
        #1;
        chk("beq_pcsrc", PCSrc, 1'b1);
        Cond = 4'b0001;
        #1;
        chk("bne_pcsrc", PCSrc, 1'b0);
        PCS = 0;

        // 3: partial flag writes
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1010;
        tick();
        chk("set_1010", Flags, 4'b1010);
        FlagW = 2'b10; ALUFlags = 4'b0101;
        tick();
        chk("nz_only_flags", Flags, 4'b0110);
        chk("nz_only_carry", Carry, 1'b1);
        FlagW = 2'b01; ALUFlags = 4'b1001;
        tick();
        chk("cv_only_flags", Flags, 4'b0101);
        chk("cv_only_carry", Carry, 1'b0);

        // Signed/unsigned compare codes with N=0 Z=1 C=0 V=1
        FlagW = 2'b00;
        Cond = 4'b1011; #1; chk("lt", CondEx, 1'b1);
        Cond = 4'b1010; #1; chk("ge", CondEx, 1'b0);
        Cond = 4'b1100; #1; chk("gt", CondEx, 1'b0);
        Cond = 4'b1101; #1; chk("le", CondEx, 1'b1);
        Cond = 4'b1000; #1; chk("hi", CondEx, 1'b0);
        Cond = 4'b1001; #1; chk("ls", CondEx, 1'b1);
        Cond = 4'b0110; #1; chk("vs", CondEx, 1'b1);
        Cond = 4'b1111; #1; chk("nv_as_al", CondEx, 1'b1);

        // 4: failing condition and flush block flag writes
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        chk("clear_flags", Flags, 4'b0000);
        Cond = 4'b0000; ALUFlags = 4'b1111; MemW = 1;
        #1;
        chk("fail_memwrite", MemWrite, 1'b0);
        tick();
        chk("fail_flags_hold", Flags, 4'b0000);
        Cond = 4'b1110; Flush = 1;
        #1;
        chk("flush_condex", CondEx, 1'b0);
        chk("flush_memwrite", MemWrite, 1'b0);
        tick();
        chk("flush_flags_hold", Flags, 4'b0000);
        Flush = 0; MemW = 0;

        // 5: stall holds flags, update on first unstalled edge
        ALUFlags = 4'b1000; Stall = 1;
        #1;
        chk("stall_condex", CondEx, 1'b1);
        tick(); chk("stall_e1", Flags, 4'b0000);
        tick(); chk("stall_e2", Flags, 4'b0000);
        tick(); chk("stall_e3", Flags, 4'b0000);
        Stall = 0;
        tick();
        chk("unstall_flags", Flags, 4'b1000);
        ALUFlags = 4'b0110; Stall = 1;
        tick();
        chk("stall2_hold", Flags, 4'b1000);
        #2 RESETn = 1'b0;
        #1;
        chk("async_rst_flags", Flags, 4'b0000);
        chk("async_rst_carry", Carry, 1'b0);
        #3 RESETn = 1'b1;
        Stall = 0;

        // 6: counters; stalled and flushed cycles are not counted
        FlagW = 2'b00; Cond = 4'b1110; Stall = 1;
        tick();
        Stall = 0; Flush = 1;
        tick();
        Flush = 0;
        for (int i = 0; i < 20; i++) tick();
        Cond = 4'b0000;
        for (int i = 0; i < 3; i++) tick();
        Valid = 0;
`ifdef COND_PERF_CNT_EN
        chk("exec_count", ExecCount, 4);
        chk("skip_count", SkipCount, 3);
`else
        chk("exec_count", ExecCount, 0);
        chk("skip_count", SkipCount, 0);
`endif
        chk("final_flags", Flags, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Sits directly downstream of the ALU in the execute stage.
- Holds the architectural NZCV flag register, updated from the ALU's ALUFlags output, and returns the registered C bit to the ALU's Carry input.
- Evaluates each instruction's 4-bit ARM condition field against the stored flags.
- Gates the decoder's PCS/RegW/MemW strobes into final PCSrc/RegWrite/MemWrite.

Parameters:
CNT_W, 32, width of the optional execute/skip counters.

Ports:
CLK  input  1  clock, all state updates on rising edge.
RESETn  input  1  asynchronous, active-low reset.
Valid  input  1  an instruction (not a bubble) occupies execute this cycle.
Stall  input  1  execute stage held; no state update.
Flush  input  1  execute instruction squashed.
Cond  input  4  instruction condition field, Instr[31:28].
ALUFlags  input  4  {N,Z,C,V} from ALU, same cycle.
FlagW  input  2  [1] write N,Z; [0] write C,V (S-bit decode).
PCS  input  1  instruction writes PC.
RegW  input  1  instruction writes register file.
MemW  input  1  instruction writes memory.
NoWrite  input  1  compare/test op: suppress RegWrite.
CondEx  output  1  condition passed for a valid, unflushed instruction.
PCSrc  output  1  gated PCS.
RegWrite  output  1  gated RegW.
MemWrite  output  1  gated MemW.
Flags  output  4  registered {N,Z,C,V}.
Carry  output  1  Flags[1], to ALU Carry input.
ExecCount  output  CNT_W  executed-instruction count (feature only).
SkipCount  output  CNT_W  condition-failed count (feature only).

Behaviour:
- Reset: RESETn low asynchronously clears Flags to 4'b0000, Carry to 0, and both counters to 0.
  - Combinational outputs follow the equations below with Flags=0.
  - With Valid=0 they are all 0.
- Condition decode (combinational, from registered Flags only; no same-cycle bypass of ALUFlags):
  - 0000 EQ: Z.  0001 NE: ~Z.
  - 0010 CS: C.  0011 CC: ~C.
  - 0100 MI: N.  0101 PL: ~N.
  - 0110 VS: V.  0111 VC: ~V.
  - 1000 HI: C&~Z.  1001 LS: ~C|Z.
  - 1010 GE: N==V.  1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V).  1101 LE: Z|(N!=V).
  - 1110 AL: 1.  1111: treated as AL (1).
- CondEx = Valid & ~Flush & condpass.
- PCSrc = PCS & CondEx.
- RegWrite = RegW & CondEx & ~NoWrite.
- MemWrite = MemW & CondEx.
- Stall does not mask these strobes; the downstream stages gate on Stall themselves.
- Flag update at rising CLK when CondEx & ~Stall:
  - FlagW[1] loads Flags[3:2] from ALUFlags[3:2].
  - FlagW[0] loads Flags[1:0] from ALUFlags[1:0].
  - Both bits set: all four load.
  - Unselected pairs hold.
- Flag update is blocked in each of these cases:
  - condition fails: a conditional flag-setting instruction that fails leaves flags unchanged;
  - Flush=1, which has priority over everything but reset;
  - Stall=1, which holds Flags for any number of cycles; the update occurs on the first non-stalled edge with CondEx still 1;
  - Valid=0.
- Latency: flags written by instruction i are visible to the CondEx of instruction i+1 on the next cycle. Back-to-back CMP then BEQ needs no extra interlock.
- Reset mid-stall or mid-flush: reset wins immediately; Flags=0.

Optional Feature:
- Macro: COND_PERF_CNT_EN.
- When defined:
  - Each rising edge with Valid & ~Flush & ~Stall increments ExecCount if condpass=1, otherwise SkipCount.
  - Both counters wrap modulo 2^CNT_W silently.
  - Counters are cleared only by reset.
- When undefined:
  - No counter registers are built.
  - ExecCount and SkipCount are tied to 0; ports remain for a stable interface.

Test Plan:
1. Reset, then hold Cond=0000, Valid=1 -> Flags=0000; EQ fails, so CondEx=0. Cond=0001 (NE) -> CondEx=1, RegWrite follows RegW.
2. CMP: Valid=1, Cond=1110, FlagW=11, ALUFlags=0100, RegW=1, NoWrite=1 -> RegWrite=0, Flags=0100 next cycle. Then BEQ (Cond=0000, PCS=1) -> PCSrc=1. BNE -> PCSrc=0.
3. Partial write: Flags=1010, FlagW=10, ALUFlags=0101 -> Flags=0110 and Carry=1, since C,V are preserved. Then FlagW=01, ALUFlags=1001 -> Flags=0101.
4. Condition fail: Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, MemW=1 -> MemWrite=0, Flags stay 0000. The same with Flush=1 and Cond=1110 -> Flags stay 0000 and CondEx=0.
5. Stall: CondEx=1, FlagW=11, ALUFlags=1000, Stall=1 for 3 cycles -> Flags unchanged for 3 edges, =1000 after the first edge with Stall=0. Assert RESETn=0 mid-stall -> Flags=0000 immediately.
6. With COND_PERF_CNT_EN and CNT_W=4: issue 20 valid AL instructions and 3 failing EQ ones (Z=0) -> ExecCount=4 (20 mod 16) and SkipCount=3. Without the macro both read 0.
